mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one single-port memory, one transaction at a time.
// Every output is registered; an ack cycle is also an IDLE cycle, so the next grant can issue in it.
module mem_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 2
) (
   input  logic        tb_clk,
   input  logic        n_rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic        m_we,
   output logic        m_oe,
   input  logic [31:0] m_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
   localparam logic [2:0]    LAT  = 3'(MEM_LAT);

   state_t        state, state_n;
   logic [2:0]    cnt, cnt_n;
   logic [SW-1:0] starve, starve_n;
   logic          own_d, own_d_n;
   logic          i_ack_n, d_ack_n, m_we_n, m_oe_n, busy_n;
   logic [31:0]   i_rdata_n, d_rdata_n, m_addr_n, m_wdata_n;
   logic          pick_d, pick_i, gnt_d, gnt_i;
   logic          unused_bits;

   assign unused_bits = ^{i_addr[1:0], d_addr[1:0]};

   // The winner is chosen from raw requests; if the winner is being acked this
   // cycle nobody is granted, so a held request cannot double-issue and the
   // loser cannot sneak in ahead of the starvation count.
   assign pick_d = d_req & (~i_req | (starve != SMAX));
   assign pick_i = i_req & ~pick_d;
   assign gnt_d  = pick_d & ~d_ack;
   assign gnt_i  = pick_i & ~i_ack;

   always_ff @(posedge tb_clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= IDLE;
         cnt     <= '0;
         starve  <= '0;
         own_d   <= 1'b0;
         i_ack   <= 1'b0;
         d_ack   <= 1'b0;
         i_rdata <= '0;
         d_rdata <= '0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_we    <= 1'b0;
         m_oe    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         starve  <= starve_n;
         own_d   <= own_d_n;
         i_ack   <= i_ack_n;
         d_ack   <= d_ack_n;
         i_rdata <= i_rdata_n;
         d_rdata <= d_rdata_n;
         m_addr  <= m_addr_n;
         m_wdata <= m_wdata_n;
         m_we    <= m_we_n;
         m_oe    <= m_oe_n;
         busy    <= busy_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      starve_n  = starve;
      own_d_n   = own_d;
      i_ack_n   = 1'b0;
      d_ack_n   = 1'b0;
      i_rdata_n = i_rdata;
      d_rdata_n = d_rdata;
      m_addr_n  = '0;
      m_wdata_n = '0;
      m_we_n    = 1'b0;
      m_oe_n    = 1'b0;
      busy_n    = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_d) begin
               own_d_n  = 1'b1;
               m_addr_n = {d_addr[31:2], 2'b00};
               busy_n   = 1'b1;
               if (i_req && starve != SMAX)
                  starve_n = starve + 1'b1;
               if (d_we) begin
                  state_n   = WR;
                  m_we_n    = 1'b1;
                  m_wdata_n = d_wdata;
               end else begin
                  state_n = RD;
                  m_oe_n  = 1'b1;
                  cnt_n   = 3'd1;
               end
            end else if (gnt_i) begin
               own_d_n  = 1'b0;
               state_n  = RD;
               m_addr_n = {i_addr[31:2], 2'b00};
               m_oe_n   = 1'b1;
               cnt_n    = 3'd1;
               busy_n   = 1'b1;
               starve_n = '0;
            end
         end
         RD: begin
            if (cnt == LAT) begin
               state_n = IDLE;
               if (own_d) begin
                  d_rdata_n = m_rdata;
                  d_ack_n   = 1'b1;
               end else begin
                  i_rdata_n = m_rdata;
                  i_ack_n   = 1'b1;
               end
            end else begin
               cnt_n    = cnt + 3'd1;
               m_oe_n   = 1'b1;
               m_addr_n = m_addr;
               busy_n   = 1'b1;
            end
         end
         WR: begin
            state_n = IDLE;
            d_ack_n = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
